// File: rtl/updown_count_monitor.sv
// Checker/display stage downstream of a 4-bit up/down counter: verifies each
// step, reports wraps and illegal transitions, and drives a registered 7-seg digit.
module updown_count_monitor #(
    parameter int WRAP_W         = 8,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        cnt_in,
    input  logic              cnt_mode,
    input  logic              cnt_rst,
    input  logic              clr,
    output logic [6:0]        seg,
    output logic              carry,
    output logic              borrow,
    output logic [WRAP_W-1:0] up_wraps,
    output logic [WRAP_W-1:0] down_wraps,
    output logic              err,
    output logic              err_sticky
);

    typedef enum logic {PRIME, TRACK} state_t;

    localparam logic [WRAP_W-1:0] WRAP_MAX  = '1;
    localparam logic [WRAP_W-1:0] WRAP_ONE  = WRAP_W'(1);
    localparam logic [6:0]        SEG_BLANK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    state_t            state_reg, state_next;
    logic [3:0]        prev_cnt_reg;
    logic              prev_mode_reg;
    logic              prev_rst_reg;
    logic [3:0]        expected;
    logic              err_next, carry_next, borrow_next;
    logic              err_reg, carry_reg, borrow_reg;
    logic              err_sticky_reg, err_sticky_next;
    logic [WRAP_W-1:0] up_wraps_reg, up_wraps_next;
    logic [WRAP_W-1:0] down_wraps_reg, down_wraps_next;
    logic [6:0]        pattern, seg_next, seg_reg;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= PRIME;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: PRIME lasts exactly one edge after reset.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            PRIME:   state_next = TRACK;
            TRACK:   state_next = TRACK;
            default: state_next = PRIME;
        endcase
    end

    // Step evaluation against the previously captured counter state.
    always_comb begin
        expected    = 4'd0;
        err_next    = 1'b0;
        carry_next  = 1'b0;
        borrow_next = 1'b0;
        if (state_reg == TRACK) begin
            if (prev_rst_reg) begin
                expected = 4'd0;
            end else if (prev_mode_reg) begin
                expected = prev_cnt_reg + 4'd1;
            end else begin
                expected = prev_cnt_reg - 4'd1;
            end
            err_next    = (cnt_in != expected);
            carry_next  = !prev_rst_reg && prev_mode_reg &&
                          (prev_cnt_reg == 4'hF) && (cnt_in == 4'h0);
            borrow_next = !prev_rst_reg && !prev_mode_reg &&
                          (prev_cnt_reg == 4'h0) && (cnt_in == 4'hF);
        end
    end

    // Tallies: clear beats a same-edge wrap; a new error beats the clear.
    always_comb begin
        up_wraps_next   = up_wraps_reg;
        down_wraps_next = down_wraps_reg;
        err_sticky_next = err_sticky_reg;
        if (clr) begin
            up_wraps_next   = '0;
            down_wraps_next = '0;
            err_sticky_next = 1'b0;
        end else begin
            if (carry_next && (up_wraps_reg != WRAP_MAX)) begin
                up_wraps_next = up_wraps_reg + WRAP_ONE;
            end
            if (borrow_next && (down_wraps_reg != WRAP_MAX)) begin
                down_wraps_next = down_wraps_reg + WRAP_ONE;
            end
        end
        if (err_next) begin
            err_sticky_next = 1'b1;
        end
    end

    // Hex decode, active-high, segment a in bit 0.
    always_comb begin
        pattern = 7'h00;
        case (cnt_in)
            4'h0: pattern = 7'h3F;
            4'h1: pattern = 7'h06;
            4'h2: pattern = 7'h5B;
            4'h3: pattern = 7'h4F;
            4'h4: pattern = 7'h66;
            4'h5: pattern = 7'h6D;
            4'h6: pattern = 7'h7D;
            4'h7: pattern = 7'h07;
            4'h8: pattern = 7'h7F;
            4'h9: pattern = 7'h6F;
            4'hA: pattern = 7'h77;
            4'hB: pattern = 7'h7C;
            4'hC: pattern = 7'h39;
            4'hD: pattern = 7'h5E;
            4'hE: pattern = 7'h79;
            4'hF: pattern = 7'h71;
            default: pattern = 7'h00;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_seg_pol
            assign seg_next[gi] = SEG_ACTIVE_LOW ? ~pattern[gi] : pattern[gi];
        end
    endgenerate

    // Capture and output registers; PRIME only captures, TRACK checks then re-captures.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_cnt_reg   <= 4'd0;
            prev_mode_reg  <= 1'b0;
            prev_rst_reg   <= 1'b0;
            err_reg        <= 1'b0;
            carry_reg      <= 1'b0;
            borrow_reg     <= 1'b0;
            err_sticky_reg <= 1'b0;
            up_wraps_reg   <= '0;
            down_wraps_reg <= '0;
            seg_reg        <= SEG_BLANK;
        end else begin
            prev_cnt_reg   <= cnt_in;
            prev_mode_reg  <= cnt_mode;
            prev_rst_reg   <= cnt_rst;
            err_reg        <= err_next;
            carry_reg      <= carry_next;
            borrow_reg     <= borrow_next;
            err_sticky_reg <= err_sticky_next;
            up_wraps_reg   <= up_wraps_next;
            down_wraps_reg <= down_wraps_next;
            seg_reg        <= seg_next;
        end
    end

    assign seg        = seg_reg;
    assign carry      = carry_reg;
    assign borrow     = borrow_reg;
    assign up_wraps   = up_wraps_reg;
    assign down_wraps = down_wraps_reg;
    assign err        = err_reg;
    assign err_sticky = err_sticky_reg;

endmodule

// File: tb/tb_updown_count_monitor.sv
// Directed bench: two monitors share stimulus, one default (8-bit tallies,
// active-low segments), one with 2-bit tallies and active-high segments.
module tb_updown_count_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] cnt_in;
    logic       cnt_mode, cnt_rst, clr;

    logic [6:0] seg8, seg2;
    logic       carry8, borrow8, err8, sticky8;
    logic       carry2, borrow2, err2, sticky2;
    logic [7:0] up8, down8;
    logic [1:0] up2, down2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    updown_count_monitor #(.WRAP_W(8), .SEG_ACTIVE_LOW(1'b1)) dut8 (
        .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .cnt_mode(cnt_mode),
        .cnt_rst(cnt_rst), .clr(clr), .seg(seg8), .carry(carry8),
        .borrow(borrow8), .up_wraps(up8), .down_wraps(down8),
        .err(err8), .err_sticky(sticky8)
    );

    updown_count_monitor #(.WRAP_W(2), .SEG_ACTIVE_LOW(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .cnt_mode(cnt_mode),
        .cnt_rst(cnt_rst), .clr(clr), .seg(seg2), .carry(carry2),
        .borrow(borrow2), .up_wraps(up2), .down_wraps(down2),
        .err(err2), .err_sticky(sticky2)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one counter value with its controls, clock it, sample 1 ns later.
    task automatic step(input logic [3:0] c, input logic m, input logic r, input logic cl);
        cnt_in   = c;
        cnt_mode = m;
        cnt_rst  = r;
        clr      = cl;
        @(posedge clk);
        #1;
        $display("step cnt=%0h mode=%0b rst=%0b clr=%0b -> seg8=%02h carry=%0b borrow=%0b err=%0b sticky=%0b up8=%0d down8=%0d up2=%0d",
                 c, m, r, cl, seg8, carry8, borrow8, err8, sticky8, up8, down8, up2);
    endtask

    initial begin
        rst_n = 1'b0; cnt_in = 4'd0; cnt_mode = 1'b1; cnt_rst = 1'b0; clr = 1'b0;
        #12;
        chk("rst_seg8", 16'(seg8), 16'h7F);
        chk("rst_seg2", 16'(seg2), 16'h00);
        chk("rst_up8", 16'(up8), 16'd0);
        chk("rst_flags8", {12'd0, carry8, borrow8, err8, sticky8}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // PRIME capture at 0, then 40 up steps with wraps at 15->0 twice.
        step(4'd0, 1'b1, 1'b0, 1'b0);
        chk("prime_err8", 16'(err8), 16'd0);
        chk("prime_seg8", 16'(seg8), 16'h40);
        for (int i = 1; i <= 40; i++) begin
            step(4'(i % 16), 1'b1, 1'b0, 1'b0);
            chk("up_carry8", 16'(carry8), 16'((i % 16) == 0));
            chk("up_carry2", 16'(carry2), 16'((i % 16) == 0));
            chk("up_err8", 16'(err8), 16'd0);
            if ((i % 16) == 5) begin
                chk("up_seg8_5", 16'(seg8), 16'h12);
                chk("up_seg2_5", 16'(seg2), 16'h6D);
            end
        end
        chk("up_wraps8", 16'(up8), 16'd2);
        chk("up_wraps2", 16'(up2), 16'd2);

        // Switch to down: 9 (still legal up step from 8), then 8..0.
        step(4'd9, 1'b0, 1'b0, 1'b0);
        chk("flip_err8", 16'(err8), 16'd0);
        for (int v = 8; v >= 1; v--) begin
            step(4'(v), 1'b0, 1'b0, 1'b0);
            chk("dn_err8", 16'(err8), 16'd0);
        end
        step(4'd0, 1'b1, 1'b0, 1'b0);        // reached 0, mode now up
        chk("bnd_borrow8", 16'(borrow8), 16'd0);
        chk("bnd_err8", 16'(err8), 16'd0);
        step(4'd1, 1'b0, 1'b0, 1'b0);        // 0->1 legal, mode back to down
        chk("bnd_up1_err8", 16'(err8), 16'd0);
        chk("bnd_up1_borrow8", 16'(borrow8), 16'd0);
        step(4'd0, 1'b0, 1'b0, 1'b0);
        step(4'd15, 1'b0, 1'b0, 1'b0);       // 0->15 down wrap
        chk("wrap_borrow8", 16'(borrow8), 16'd1);
        chk("wrap_borrow2", 16'(borrow2), 16'd1);
        chk("wrap_down8", 16'(down8), 16'd1);
        chk("wrap_err8", 16'(err8), 16'd0);
        step(4'd14, 1'b1, 1'b0, 1'b0);
        chk("borrow_pulse_end", 16'(borrow8), 16'd0);

        // Counter reset at 15 while counting up: 15->0 is not a carry.
        step(4'd15, 1'b1, 1'b1, 1'b0);
        step(4'd0, 1'b1, 1'b0, 1'b0);
        chk("crst_carry8", 16'(carry8), 16'd0);
        chk("crst_err8", 16'(err8), 16'd0);
        chk("crst_up8", 16'(up8), 16'd2);
        step(4'd1, 1'b1, 1'b0, 1'b0);
        step(4'd2, 1'b1, 1'b0, 1'b0);
        step(4'd3, 1'b1, 1'b0, 1'b0);
        step(4'd9, 1'b1, 1'b0, 1'b0);        // illegal jump 3->9
        chk("jump_err8", 16'(err8), 16'd1);
        chk("jump_sticky8", 16'(sticky8), 16'd1);
        step(4'd10, 1'b1, 1'b0, 1'b0);
        chk("jump_err_end", 16'(err8), 16'd0);
        chk("jump_sticky_hold", 16'(sticky8), 16'd1);
        step(4'd11, 1'b1, 1'b0, 1'b1);       // clr
        chk("clr_sticky8", 16'(sticky8), 16'd0);
        chk("clr_up8", 16'(up8), 16'd0);
        chk("clr_down8", 16'(down8), 16'd0);
        chk("clr_err8", 16'(err8), 16'd0);
        step(4'd5, 1'b1, 1'b0, 1'b1);        // illegal jump on a clr edge
        chk("clrerr_err8", 16'(err8), 16'd1);
        chk("clrerr_sticky8", 16'(sticky8), 16'd1);
        step(4'd6, 1'b1, 1'b0, 1'b0);
        chk("clrerr_sticky_hold", 16'(sticky8), 16'd1);

        // Five up-wraps: 2-bit tally saturates at 3.
        for (int k = 1; k <= 74; k++) begin
            step(4'((6 + k) % 16), 1'b1, 1'b0, 1'b0);
        end
        chk("sat_up8", 16'(up8), 16'd5);
        chk("sat_up2", 16'(up2), 16'd3);
        chk("sat_carry2", 16'(carry2), 16'd1);

        // Asynchronous reset mid-cycle, with a carry pulse pending on the outputs.
        rst_n = 1'b0;
        #1;
        chk("arst_seg8", 16'(seg8), 16'h7F);
        chk("arst_seg2", 16'(seg2), 16'h00);
        chk("arst_up8", 16'(up8), 16'd0);
        chk("arst_up2", 16'(up2), 16'd0);
        chk("arst_flags8", {12'd0, carry8, borrow8, err8, sticky8}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'd3, 1'b1, 1'b0, 1'b0);        // PRIME edge: arbitrary value, no error
        chk("rel_err8", 16'(err8), 16'd0);
        chk("rel_carry8", 16'(carry8), 16'd0);

        // One carry, then a carry on a clr edge: tally 0, pulse still fires.
        for (int v = 4; v <= 15; v++) begin
            step(4'(v), 1'b1, 1'b0, 1'b0);
        end
        step(4'd0, 1'b1, 1'b0, 1'b0);
        chk("pre_clr_up8", 16'(up8), 16'd1);
        chk("pre_clr_up2", 16'(up2), 16'd1);
        for (int v = 1; v <= 15; v++) begin
            step(4'(v), 1'b1, 1'b0, 1'b0);
        end
        step(4'd0, 1'b1, 1'b0, 1'b1);
        chk("clrwrap_carry8", 16'(carry8), 16'd1);
        chk("clrwrap_up8", 16'(up8), 16'd0);
        chk("clrwrap_up2", 16'(up2), 16'd0);
        chk("clrwrap_err8", 16'(err8), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/updown_count_monitor.md
# updown_count_monitor

Checker and display stage that sits directly downstream of the 4-bit up/down counter. It samples the counter value together with the counter's own `mode` and `rst` controls, and checks every step against the expected ±1 (mod 16) behaviour. It reports carry and borrow wrap events, keeps saturating wrap tallies, flags illegal transitions, and drives a registered seven-segment pattern of the current count for the board display.

## Interface
- `WRAP_W`, default 8: width of each wrap tally, 1..16.
- `SEG_ACTIVE_LOW`, default 1: 1 = segments driven active-low (common anode); 0 = active-high.
- `clk` input 1: single clock, the same clock as the counter; all logic updates on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low; forces every register to its reset value.
- `cnt_in` input 4: the counter's `out`.
- `cnt_mode` input 1: the counter's `mode` (1 = up, 0 = down), tapped at the same point the counter sees it.
- `cnt_rst` input 1: the counter's synchronous `rst`, active-high.
- `clr` input 1: synchronous clear of the tallies and the sticky error flag.
- `seg` output 7: segments {g,f,e,d,c,b,a} for hex digit `cnt_in`, registered.
- `carry` output 1: one-cycle pulse on an up-wrap, 15→0.
- `borrow` output 1: one-cycle pulse on a down-wrap, 0→15.
- `up_wraps` output WRAP_W: saturating count of carry events.
- `down_wraps` output WRAP_W: saturating count of borrow events.
- `err` output 1: one-cycle pulse on an illegal transition.
- `err_sticky` output 1: set by `err`; held until `clr` or reset.

## Operation
State machine, two states:
- **PRIME**
  - Entered on reset.
  - On the next edge, captures `prev_cnt` ← `cnt_in`, `prev_mode` ← `cnt_mode`, `prev_rst` ← `cnt_rst`.
  - Performs no check and produces no pulses.
  - Goes to TRACK.
- **TRACK**
  - Every edge evaluates `cnt_in` against the captured `prev_*` values, then re-captures them.
  - Stays in TRACK until reset.

Expected value in TRACK:
- If `prev_rst` = 1: expected value is 0.
- Else if `prev_mode` = 1: expected value is `prev_cnt` + 1, mod 16.
- Else: expected value is `prev_cnt` − 1, mod 16.
- All arithmetic is 4-bit and wraps naturally; no sign extension.

Outcome of each TRACK evaluation:
- `cnt_in` ≠ expected: `err` = 1 and `err_sticky` is set.
- `carry` = 1 when `prev_rst` = 0, `prev_mode` = 1, `prev_cnt` = 15 and `cnt_in` = 0.
- `borrow` = 1 when `prev_rst` = 0, `prev_mode` = 0, `prev_cnt` = 0 and `cnt_in` = 15.
- A counter reset from 15 to 0 is not a carry.

Tallies:
- A `carry` increments `up_wraps`; a `borrow` increments `down_wraps`.
- Both saturate at 2^WRAP_W − 1 and never roll over.

`clr` behaviour:
- `clr` = 1 zeroes both tallies and `err_sticky` on that edge.
- If `clr` and a wrap event occur on the same edge, `clr` wins: the tally is 0 afterwards.
- The `carry`/`borrow`/`err` pulses still fire on a `clr` edge.
- If `clr` and `err` occur on the same edge, `err_sticky` ends set; the new error takes priority over the clear.
- `clr` does not affect the state machine or the `prev_*` registers.

`seg` decode:
- `seg` is the hex decode (0–F) of `cnt_in`, registered every edge, including in PRIME.
- Active-high patterns, a in bit 0:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Each pattern is inverted when SEG_ACTIVE_LOW = 1.

## Timing
- Reset values, while `rst_n` = 0:
  - state = PRIME.
  - `carry` = `borrow` = `err` = `err_sticky` = 0.
  - Tallies = 0.
  - `prev_*` = 0.
  - `seg` = blank: all segments off, i.e. 7'h7F when SEG_ACTIVE_LOW = 1, 7'h00 otherwise.
- Reset asserted mid-operation: all outputs go to their reset values immediately (asynchronous); any pending pulse is lost.
- After `rst_n` deasserts, the first edge is the PRIME capture. Checking starts on the second edge.
- Latency: a transition visible on `cnt_in` at edge n produces `carry`/`borrow`/`err` and the tally update on the outputs right after edge n, and `seg` likewise. All are valid in cycle n..n+1.
- Pulses last exactly one cycle. Back-to-back events give back-to-back pulses.
- The upstream counter changes `cnt_in` only on `clk` edges, so `cnt_in`, `cnt_mode` and `cnt_rst` are stable at the sampling edge with no synchronisers.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-count.
  - `seg` = 7F, tallies 0, flags 0, asynchronously before the next edge.
  - After release, no `err` on the first edge.
- **Up-count:** `cnt_mode` = 1, counter runs 0→15→0→…, 40 steps.
  - `carry` pulses at each 15→0, 2 in total: `up_wraps` = 2, `err` never 1.
  - `seg` tracks the count (5 → 7'h12 with SEG_ACTIVE_LOW = 1).
- **Mode flip at a boundary:** counting down through 1→0, switch `cnt_mode` to 1 while at 0.
  - No `borrow`, next value 1 is legal.
  - Then stay down at 0: the 0→15 step gives `borrow` = 1 and `down_wraps` += 1.
- **Counter reset and illegal jump:**
  - Pulse `cnt_rst` at count 15, mode up → 0 is legal: no `carry`, no `err`.
  - Force `cnt_in` from 3 to 9 → `err` pulse for 1 cycle, `err_sticky` = 1 until `clr`.
- **Saturation and `clr`:** WRAP_W = 2, 5 up-wraps.
  - `up_wraps` sticks at 3.
  - `clr` on the same edge as a carry → `up_wraps` = 0 and `carry` still pulses.
